// File: rtl/invsqrt_pwl_eval.sv
// Pipelined 1/sqrt(x) for unsigned fixed point: normalize x to m in [1,2), evaluate an
// 8-segment piecewise-linear fit of 1/sqrt(m), then fold the halved exponent back in.

module invsqrt_lin_lut #(
  parameter int WIDTH     = 48,
  parameter int FRAC_BITS = 16
) (
  input  logic [2:0]       idx,
  output logic [WIDTH-1:0] a0,
  output logic [WIDTH-1:0] a1
);
  localparam int UP = (FRAC_BITS >= 16) ? FRAC_BITS - 16 : 0;
  localparam int DN = (FRAC_BITS < 16) ? 16 - FRAC_BITS : 0;

  logic signed [WIDTH-1:0] a0_q16;
  logic signed [WIDTH-1:0] a1_q16;

  // Chords of 1/sqrt(1+f) through the ends of each eighth of f, held in Q.16
  always_comb begin
    a0_q16 = WIDTH'(32'sd65536);
    a1_q16 = WIDTH'(-32'sd29985);
    case (idx)
      3'd0: begin a0_q16 = WIDTH'(32'sd65536); a1_q16 = WIDTH'(-32'sd29985); end
      3'd1: begin a0_q16 = WIDTH'(32'sd64959); a1_q16 = WIDTH'(-32'sd25366); end
      3'd2: begin a0_q16 = WIDTH'(32'sd64073); a1_q16 = WIDTH'(-32'sd21823); end
      3'd3: begin a0_q16 = WIDTH'(32'sd63027); a1_q16 = WIDTH'(-32'sd19035); end
      3'd4: begin a0_q16 = WIDTH'(32'sd61907); a1_q16 = WIDTH'(-32'sd16794); end
      3'd5: begin a0_q16 = WIDTH'(32'sd60761); a1_q16 = WIDTH'(-32'sd14961); end
      3'd6: begin a0_q16 = WIDTH'(32'sd59620); a1_q16 = WIDTH'(-32'sd13439); end
      3'd7: begin a0_q16 = WIDTH'(32'sd58499); a1_q16 = WIDTH'(-32'sd12158); end
    endcase
  end

  assign a0 = (a0_q16 <<< UP) >>> DN;
  assign a1 = (a1_q16 <<< UP) >>> DN;
endmodule

module invsqrt_pwl_eval #(
  parameter int WIDTH     = 48,
  parameter int FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);
  localparam int PW    = $clog2(WIDTH);
  localparam int EW    = PW + 2;
  localparam int PRODW = WIDTH + FRAC_BITS + 1;
  localparam int BIGW  = WIDTH + FRAC_BITS + 1;
  localparam logic [16:0] RSQRT2 = 17'h0B505;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic                   s0_valid;
  logic [WIDTH-1:0]       s0_x;
  logic                   s1_valid;
  logic [FRAC_BITS-1:0]   s1_f;
  logic signed [EW-1:0]   s1_e;
  logic                   s1_zero;
  logic                   s2_valid;
  logic [WIDTH-1:0]       s2_a0;
  logic signed [WIDTH:0]  s2_prod;
  logic signed [EW-1:0]   s2_e;
  logic                   s2_zero;
  logic                   s3_valid;
  logic [WIDTH:0]         s3_y;
  logic signed [EW-1:0]   s3_k;
  logic                   s3_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_x     <= '0;
    end else if (en) begin
      s0_valid <= in_valid;
      s0_x     <= in_data;
    end
  end

  // Leading-one search; f is x shifted so that leading one sits just above the fraction
  logic [PW-1:0]          lead;
  logic [FRAC_BITS-1:0]   f_c;
  logic signed [EW-1:0]   e_c;

  always_comb begin
    lead = '0;
    for (int i = 0; i < WIDTH; i++)
      if (s0_x[i]) lead = PW'(i);
    if (int'(lead) >= FRAC_BITS)
      f_c = FRAC_BITS'(s0_x >> (int'(lead) - FRAC_BITS));
    else
      f_c = FRAC_BITS'(s0_x << (FRAC_BITS - int'(lead)));
    e_c = EW'(int'(lead) - FRAC_BITS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_f     <= '0;
      s1_e     <= '0;
      s1_zero  <= 1'b0;
    end else if (en) begin
      s1_valid <= s0_valid;
      s1_f     <= f_c;
      s1_e     <= e_c;
      s1_zero  <= (s0_x == '0);
    end
  end

  logic [WIDTH-1:0]        lut_a0;
  logic [WIDTH-1:0]        lut_a1;
  logic signed [PRODW-1:0] prod_full;
  logic signed [WIDTH:0]   prod_c;

  invsqrt_lin_lut #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_lut (
    .idx (s1_f[FRAC_BITS-1 -: 3]),
    .a0  (lut_a0),
    .a1  (lut_a1)
  );

  always_comb begin
    prod_full = PRODW'($signed(lut_a1)) * PRODW'($signed({1'b0, s1_f}));
    prod_c    = (WIDTH+1)'(prod_full >>> FRAC_BITS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_a0    <= '0;
      s2_prod  <= '0;
      s2_e     <= '0;
      s2_zero  <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_a0    <= lut_a0;
      s2_prod  <= prod_c;
      s2_e     <= s1_e;
      s2_zero  <= s1_zero;
    end
  end

  // An odd exponent leaves one factor of sqrt(2) that the integer shift cannot absorb
  logic signed [WIDTH+1:0] y_sum;
  logic [WIDTH:0]          y_pos;
  logic [WIDTH+16:0]       y_scaled;
  logic [WIDTH:0]          y_c;

  always_comb begin
    y_sum    = $signed({2'b00, s2_a0}) + (WIDTH+2)'(s2_prod);
    y_pos    = y_sum[WIDTH+1] ? '0 : y_sum[WIDTH:0];
    y_scaled = (WIDTH+17)'(y_pos) * (WIDTH+17)'(RSQRT2);
    y_c      = s2_e[0] ? (WIDTH+1)'(y_scaled >> 16) : y_pos;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_y     <= '0;
      s3_k     <= '0;
      s3_zero  <= 1'b0;
    end else if (en) begin
      s3_valid <= s2_valid;
      s3_y     <= y_c;
      s3_k     <= s2_e >>> 1;
      s3_zero  <= s2_zero;
    end
  end

  // Left shifts run in a widened word so any bit pushed past WIDTH-1 is seen and saturates
  logic [BIGW-1:0]  big;
  logic [EW-1:0]    shl;
  logic [WIDTH:0]   rsh;
  logic [WIDTH-1:0] res_c;
  logic             sat;

  always_comb begin
    big   = '0;
    shl   = '0;
    rsh   = '0;
    res_c = '0;
    sat   = 1'b0;
    if (s3_k < 0) begin
      shl   = EW'(-s3_k);
      big   = BIGW'(s3_y) << shl;
      sat   = |big[BIGW-1:WIDTH];
      res_c = big[WIDTH-1:0];
    end else begin
      rsh   = s3_y >> s3_k;
      sat   = rsh[WIDTH];
      res_c = rsh[WIDTH-1:0];
    end
    if (sat) res_c = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b0;
    end else if (en) begin
      out_valid <= s3_valid;
      out_data  <= s3_zero ? '1 : res_c;
      out_zero  <= s3_zero;
    end
  end
endmodule

// File: tb/tb_invsqrt_pwl_eval.sv
// Directed self-checking bench for invsqrt_pwl_eval: latency, zero/saturation corners,
// backpressure, a random sweep against a real-valued 1/sqrt model, and mid-stream reset.

module tb_invsqrt_pwl_eval;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [47:0] in_data, out_data;
  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_zero;
  logic [19:0] n_in_data, n_out_data;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  invsqrt_pwl_eval #(.WIDTH(48), .FRAC_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero)
  );

  invsqrt_pwl_eval #(.WIDTH(20), .FRAC_BITS(16)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data), .out_zero(n_out_zero)
  );

  // Ideal 1/sqrt(x) in output LSBs for Q32.16: 2^16 / sqrt(x / 2^16) = 2^24 / sqrt(x)
  function automatic real ideal_of(input logic [47:0] x);
    return 16777216.0 / $sqrt(real'(x));
  endfunction

  // Distance beyond the allowed 0.5% relative + 1 LSB band (> 0 means out of band)
  function automatic real excess(input logic [47:0] got, input real ideal);
    real d;
    d = real'(got) - ideal;
    if (d < 0.0) d = -d;
    return d - (0.005 * ideal + 1.0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 0; in_data = '0; out_ready = 1;
    n_in_valid = 0; n_in_data = '0; n_out_ready = 1;
    rst_n = 1;
    #1 rst_n = 0;
    #2;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++;
    if (out_data !== 48'h0) begin n_fail++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    n_cmp++;
    if (out_zero !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_zero: got %b expected 0", out_zero); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL post_reset_idle: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] xs  [4] = '{48'h10000, 48'h40000, 48'h20000, 48'h4000};
    logic [47:0] exps[4] = '{48'h10000, 48'h8000, 48'hB505, 48'h20000};
    out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 4);
      in_data  = (c < 4) ? xs[c] : '0;
      #1;
      n_cmp++;
      if (out_valid !== ((c >= 5 && c <= 8) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("[TB] FAIL b2b_valid[c%0d]: got %b", c, out_valid);
      end
      if (c >= 5 && c <= 8) begin
        n_cmp++;
        if (excess(out_data, real'(exps[c-5])) > 0.0) begin
          n_fail++; $display("[TB] FAIL b2b_data[%0d]: got %h expected ~%h", c - 5, out_data, exps[c-5]);
        end
      end
      tick();
    end
    in_valid = 0;
  endtask

  task automatic test_zero_min();
    out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 2);
      in_data  = (c == 1) ? 48'h1 : 48'h0;
      #1;
      n_cmp++;
      if (out_valid !== ((c == 5 || c == 6) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("[TB] FAIL zmin_valid[c%0d]: got %b", c, out_valid);
      end
      if (c == 5) begin
        n_cmp++;
        if (out_data !== 48'hFFFF_FFFF_FFFF || out_zero !== 1'b1) begin
          n_fail++; $display("[TB] FAIL zero_input: got data=%h zero=%b expected ffffffffffff/1", out_data, out_zero);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (excess(out_data, 16777216.0) > 0.0 || out_zero !== 1'b0) begin
          n_fail++; $display("[TB] FAIL min_input: got data=%h zero=%b expected ~1000000/0", out_data, out_zero);
        end
      end
      tick();
    end
    in_valid = 0;
  endtask

  task automatic test_segments();
    logic [47:0] xs[8];
    for (int i = 0; i < 8; i++) xs[i] = 48'h11000 + 48'(i) * 48'h2000;
    out_ready = 1;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 8);
      in_data  = (c < 8) ? xs[c] : '0;
      #1;
      if (c >= 5 && c <= 12) begin
        n_cmp++;
        if (out_valid !== 1'b1 || excess(out_data, ideal_of(xs[c-5])) > 0.0) begin
          n_fail++; $display("[TB] FAIL segment_mid[%0d]: got valid=%b data=%0d expected ~%0.1f", c - 5, out_valid, out_data, ideal_of(xs[c-5]));
        end
      end
      tick();
    end
    in_valid = 0;
  endtask

  task automatic test_saturation();
    logic [19:0] xs[3] = '{20'h1, 20'h10000, 20'h0};
    n_out_ready = 1;
    for (int c = 0; c < 9; c++) begin
      n_in_valid = (c < 3);
      n_in_data  = (c < 3) ? xs[c] : '0;
      #1;
      n_cmp++;
      if (n_out_valid !== ((c >= 5 && c <= 7) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("[TB] FAIL narrow_valid[c%0d]: got %b", c, n_out_valid);
      end
      if (c == 5) begin
        n_cmp++;
        if (n_out_data !== 20'hFFFFF || n_out_zero !== 1'b0) begin
          n_fail++; $display("[TB] FAIL saturate: got data=%h zero=%b expected fffff/0", n_out_data, n_out_zero);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (n_out_data !== 20'h10000 || n_out_zero !== 1'b0) begin
          n_fail++; $display("[TB] FAIL narrow_one: got data=%h zero=%b expected 10000/0", n_out_data, n_out_zero);
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (n_out_data !== 20'hFFFFF || n_out_zero !== 1'b1) begin
          n_fail++; $display("[TB] FAIL narrow_zero: got data=%h zero=%b expected fffff/1", n_out_data, n_out_zero);
        end
      end
      tick();
    end
    n_in_valid = 0;
  endtask

  task automatic test_backpressure();
    logic [47:0] xs[8] = '{48'h10000, 48'h90000, 48'h4000, 48'h1, 48'h1_2345_6789,
                           48'h24000, 48'h640000, 48'h8000};
    logic [47:0] q[$];
    logic [47:0] held, x;
    logic        exp_rdy;
    int issued = 0;
    int retired = 0;
    for (int c = 0; c < 40 && retired < 8; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      in_valid  = (issued < 8);
      in_data   = (issued < 8) ? xs[issued] : '0;
      #1;
      exp_rdy = !(c >= 5 && c <= 7);
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_fail++; $display("[TB] FAIL bp_in_ready[c%0d]: got %b expected %b", c, in_ready, exp_rdy);
      end
      if (c == 5) held = out_data;
      if (c == 6 || c == 7) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          n_fail++; $display("[TB] FAIL bp_hold[c%0d]: got valid=%b data=%h expected 1/%h", c, out_valid, out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++; $display("[TB] FAIL bp_spurious: got result %h with nothing outstanding", out_data);
        end else begin
          x = q.pop_front();
          if (excess(out_data, ideal_of(x)) > 0.0) begin
            n_fail++; $display("[TB] FAIL bp_result[%0d]: got %0d expected ~%0.1f", retired, out_data, ideal_of(x));
          end
        end
        retired++;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        issued++;
      end
      tick();
    end
    in_valid = 0; out_ready = 1;
    n_cmp++;
    if (retired != 8) begin n_fail++; $display("[TB] FAIL bp_count: got %0d results expected 8", retired); end
  endtask

  task automatic test_random();
    logic [47:0] q[$];
    logic [47:0] x;
    int issued = 0;
    int retired = 0;
    int bad = 0;
    out_ready = 1;
    for (int c = 0; c < 10100 && retired < 10000; c++) begin
      in_valid = (issued < 10000);
      in_data  = 48'({$urandom(), $urandom()} >> $urandom_range(0, 47));
      #1;
      if (out_valid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++; $display("[TB] FAIL rand_spurious: got result %h with nothing outstanding", out_data);
        end else begin
          x = q.pop_front();
          if (x == 48'h0) begin
            if (out_data !== 48'hFFFF_FFFF_FFFF || out_zero !== 1'b1) begin
              n_fail++; bad++;
              if (bad < 10) $display("[TB] FAIL rand_zero: got %h/%b expected ffffffffffff/1", out_data, out_zero);
            end
          end else if (excess(out_data, ideal_of(x)) > 0.0 || out_zero !== 1'b0) begin
            n_fail++; bad++;
            if (bad < 10) $display("[TB] FAIL rand_result x=%h: got %0d expected ~%0.3f", x, out_data, ideal_of(x));
          end
        end
        retired++;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        issued++;
      end
      tick();
    end
    in_valid = 0;
    n_cmp++;
    if (retired != 10000) begin n_fail++; $display("[TB] FAIL rand_count: got %0d results expected 10000", retired); end
  endtask

  task automatic test_reset_midstream();
    logic [47:0] xs[4] = '{48'h40000, 48'h90000, 48'h4000, 48'h640000};
    out_ready = 1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 4);
      in_data  = (c < 4) ? xs[c] : '0;
      tick();
    end
    in_valid = 0;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_flush_valid: got %b expected 1", out_valid); end
    #1 rst_n = 0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 48'h0 || out_zero !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL flush_outputs: got valid=%b data=%h zero=%b ready=%b expected 0/0/0/1", out_valid, out_data, out_zero, in_ready);
    end
    @(posedge clk);
    #3 rst_n = 1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 0);
      in_data  = (c == 0) ? 48'h10000 : '0;
      #1;
      n_cmp++;
      if (out_valid !== ((c == 5) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("[TB] FAIL post_flush_valid[c%0d]: got %b", c, out_valid);
      end
      if (c == 5) begin
        n_cmp++;
        if (excess(out_data, 65536.0) > 0.0) begin
          n_fail++; $display("[TB] FAIL post_flush_data: got %h expected ~10000", out_data);
        end
      end
      tick();
    end
    in_valid = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_zero_min();
    test_segments();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/invsqrt_pwl_eval.md
# invsqrt_pwl_eval

Pipelined fixed-point inverse-square-root evaluator for the AdaIN arithmetic unit; it consumes the 8-segment piecewise-linear coefficient table `invsqrt_lin_lut` (`A0` intercept, `A1` slope, indexed by `idx`). It takes a per-channel variance (epsilon already added upstream) and returns 1/sqrt(x) to the AdaIN scale multiplier. Range reduction, table lookup, linear interpolation and exponent correction use a 4-stage valid/ready pipeline with throughput of one sample per cycle.

## Interface
- `WIDTH`, 48, data width; input and output are unsigned Q(WIDTH-FRAC_BITS).FRAC_BITS.
- `FRAC_BITS`, 16, fractional bits; must be at least 3.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  the block accepts the sample this cycle.
- `in_data`  in  WIDTH  x, unsigned Q(WIDTH-FRAC_BITS).FRAC_BITS.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  WIDTH  1/sqrt(x), same Q format, saturating.
- `out_zero`  out  1  the input was 0 (result forced to all-ones).

## Operation
- The block instantiates one `invsqrt_lin_lut` with the same WIDTH and FRAC_BITS. `A0` is an unsigned Q.FRAC_BITS intercept. `A1` is a signed, sign-extended Q.FRAC_BITS slope.
- **S1, normalize.**
  - p = index of the leading one of x.
  - e = p - FRAC_BITS, a signed exponent.
  - Shift x so the leading one lands at bit FRAC_BITS.
  - f = normalized bits [FRAC_BITS-1:0], in Q0.FRAC_BITS; m = 1+f lies in [1,2).
  - idx = f[FRAC_BITS-1:FRAC_BITS-3].
  - zero = (x==0).
- **S2, lookup and slope.** Register A0, and register prod = A1*f as a signed full-width product, arithmetically shifted right by FRAC_BITS.
- **S3, interpolate.**
  - y = A0 + prod, approximating 1/sqrt(m) in (0.70,1.0].
  - k = e>>>1 (floor).
  - If e is odd, y = (y*16'hB505)>>16, where 0xB505 is 1/sqrt(2) in Q0.16.
- **S4, scale and saturate.**
  - For k≥0, out = y>>k (logical).
  - For k<0, out = y<<(-k). If any set bit would be shifted out or land above bit WIDTH-1, out = {WIDTH{1'b1}}.
  - For zero, out = {WIDTH{1'b1}} and out_zero=1.
- Intermediate widths: the product is WIDTH+FRAC_BITS+1 bits signed, and y is kept at WIDTH+1 bits before saturation. Negative y cannot occur with a valid table; if it does, clamp y to 0.
- All stage registers advance on enable en = !out_valid | out_ready, so the pipeline stalls as a whole. in_ready = en.
- A bubble (in_valid=0 with en=1) propagates as valid=0; data registers may hold stale values.

## Timing
- Latency: a sample accepted at edge N produces out_valid=1 after edge N+4, assuming no stall.
- Throughput: 1 sample per cycle while out_ready=1.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data and out_zero hold stable and in_ready=0.
  - in_ready is combinational from out_valid and out_ready.
  - No sample is dropped or duplicated, and order is preserved.
- Simultaneous out_ready=1 with out_valid=1 and in_valid=1: the result retires and the new sample enters in the same edge.
- Reset (rst_n=0, async):
  - All stage valid bits, out_valid, out_data and out_zero go to 0 immediately.
  - in_ready reads 1 during and after reset.
  - In-flight samples are discarded.
  - The first edge with rst_n=1 may accept a sample.
- Accuracy: |out - 1/sqrt(x)| ≤ 0.5% relative, plus 1 LSB, for all non-saturating x.

## Test plan
- WIDTH=48, FRAC=16, 4 inputs back to back with out_ready=1: x=0x10000 (1.0) -> ≈0x10000; x=0x40000 (4.0) -> ≈0x8000; x=0x20000 (2.0) -> ≈0xB505; x=0x4000 (0.25) -> ≈0x20000. Results must appear on 4 consecutive cycles, 4 cycles after input, each within tolerance.
- Zero and minimum inputs:
  - x=0 -> out_data=0xFFFF_FFFF_FFFF, out_zero=1.
  - x=1 (2^-16) -> 256.0 = 0x100_0000 within tolerance, out_zero=0.
- Saturation: x=0x1, with FRAC_BITS=16 and WIDTH=20 -> out_data all-ones, out_zero=0.
- Backpressure: stream 8 random x, and drop out_ready for cycles 5–7.
  - in_ready must fall on those cycles.
  - out_data must be held while stalled.
  - All 8 results must match the model, in order.
- Randomized check: 10k random x across the full range against a double-precision model, with the relative-error bound checked.
- Reset mid-stream: assert rst_n=0 for 1 cycle while 3 samples are in flight.
  - Outputs must be 0 immediately and in_ready=1.
  - None of the 3 flushed samples may appear.
  - A post-reset x=0x10000 must produce ≈0x10000 after 4 cycles.
